// File: rtl/wormhole_router.sv
// Flattened-butterfly wormhole router node: per-input FIFOs, dimension-order routing, per-output locking.
// Define ROUTER_PKT_CNT_EN to add pkt_cnt_o (per-output tail-flit counters).
module wormhole_router #(
  parameter int DATA_W       = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int NODE_PER_ROW = 4,
  parameter int NODE_PER_COL = 4,
  parameter int INPORT       = 7,
  parameter int OUTPORT      = 7,
  parameter int AF_SLACK     = 2,
  parameter int curr_dim0    = 0,
  parameter int curr_dim1    = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [INPORT-1:0]         valid_i,
  input  logic [INPORT*DATA_W-1:0]  data_i,
  input  logic [OUTPORT-1:0]        off_sigs_i,
  output logic [OUTPORT-1:0]        valid_o,
  output logic [OUTPORT*DATA_W-1:0] data_o,
  output logic [INPORT-1:0]         off_sigs_o,
  output logic [INPORT-1:0]         err_o
`ifdef ROUTER_PKT_CNT_EN
  ,
  output logic [OUTPORT*16-1:0]     pkt_cnt_o
`endif
);
  localparam int DIM0_W = $clog2(NODE_PER_ROW);
  localparam int DIM1_W = $clog2(NODE_PER_COL);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int IN_W   = $clog2(INPORT);
  localparam int OUT_W  = $clog2(OUTPORT);

  logic [DATA_W-1:0] front [INPORT];
  logic [OUT_W-1:0]  route [INPORT];
  logic [IN_W-1:0]   src   [OUTPORT];
  logic [INPORT-1:0] nonempty, req, pop, discard;
  logic [OUTPORT-1:0] xfer;

  for (genvar gi = 0; gi < INPORT; gi++) begin : g_in
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              active_reg, err_reg, full, wr_en;
    logic [OUT_W-1:0]  route_reg, route_loc;
    logic [DIM0_W-1:0] dst0;
    logic [DIM1_W-1:0] dst1;

    assign full          = (count_reg == CNT_W'(FIFO_DEPTH));
    assign wr_en         = valid_i[gi] && (!full || pop[gi]);
    assign front[gi]     = mem[rd_ptr_reg];
    assign nonempty[gi]  = (count_reg != '0);
    assign off_sigs_o[gi] = (count_reg >= CNT_W'(FIFO_DEPTH - AF_SLACK));
    assign discard[gi]   = nonempty[gi] && !active_reg && !front[gi][0];
    assign req[gi]       = nonempty[gi] && !active_reg && front[gi][0];
    assign dst0          = front[gi][2 +: DIM0_W];
    assign dst1          = front[gi][2+DIM0_W +: DIM1_W];
    assign err_o[gi]     = err_reg;
    // Head route is only meaningful while idle; an active input follows its latched route.
    assign route[gi]     = active_reg ? route_reg : route_loc;

    always_comb begin
      route_loc = '0;
      if (int'(dst0) != curr_dim0)
        route_loc = OUT_W'(1 + ((int'(dst0) < curr_dim0) ? int'(dst0) : int'(dst0) - 1));
      else if (int'(dst1) != curr_dim1)
        route_loc = OUT_W'(NODE_PER_ROW + ((int'(dst1) < curr_dim1) ? int'(dst1) : int'(dst1) - 1));
    end

    always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_reg] <= data_i[gi*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
        active_reg <= 1'b0;
        route_reg  <= '0;
        err_reg    <= 1'b0;
      end else begin
        if (wr_en)   wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop[gi]) rd_ptr_reg <= rd_ptr_reg + 1'b1;
        if (wr_en && !pop[gi])      count_reg <= count_reg + 1'b1;
        else if (!wr_en && pop[gi]) count_reg <= count_reg - 1'b1;
        if ((valid_i[gi] && !wr_en) || discard[gi]) err_reg <= 1'b1;
        if (pop[gi] && !discard[gi]) begin
          if (!active_reg && !front[gi][1]) begin
            active_reg <= 1'b1;
            route_reg  <= route_loc;
          end else if (active_reg && front[gi][1]) begin
            active_reg <= 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    pop = discard;
    for (int o = 0; o < OUTPORT; o++)
      for (int v = 0; v < INPORT; v++)
        if (xfer[o] && src[o] == IN_W'(v)) pop[v] = 1'b1;
  end

  for (genvar go = 0; go < OUTPORT; go++) begin : g_out
    logic [INPORT-1:0] req_vec;
    logic              locked_reg, valid_reg, found;
    logic [IN_W-1:0]   owner_reg, ptr_reg, winner;
    logic [DATA_W-1:0] data_reg, flit;

    always_comb begin
      for (int v = 0; v < INPORT; v++)
        req_vec[v] = req[v] && (route[v] == OUT_W'(go));
    end

    // Round-robin search starting at the pointer.
    always_comb begin
      winner = '0;
      found  = 1'b0;
      for (int i = 0; i < INPORT; i++) begin
        int idx;
        idx = int'(ptr_reg) + i;
        if (idx >= INPORT) idx = idx - INPORT;
        if (!found && req_vec[idx]) begin
          found  = 1'b1;
          winner = IN_W'(idx);
        end
      end
    end

    assign src[go]  = locked_reg ? owner_reg : winner;
    assign xfer[go] = !off_sigs_i[go] && (locked_reg ? nonempty[owner_reg] : found);
    assign flit     = front[src[go]];
    assign valid_o[go] = valid_reg;
    assign data_o[go*DATA_W +: DATA_W] = data_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        locked_reg <= 1'b0;
        owner_reg  <= '0;
        ptr_reg    <= '0;
        valid_reg  <= 1'b0;
        data_reg   <= '0;
      end else begin
        valid_reg <= xfer[go];
        if (xfer[go]) begin
          data_reg <= flit;
          if (locked_reg) begin
            if (flit[1]) locked_reg <= 1'b0;
          end else begin
            ptr_reg <= (winner == IN_W'(INPORT-1)) ? '0 : winner + 1'b1;
            if (!flit[1]) begin
              locked_reg <= 1'b1;
              owner_reg  <= winner;
            end
          end
        end
      end
    end

`ifdef ROUTER_PKT_CNT_EN
    logic [15:0] pkt_cnt_reg;
    always_ff @(posedge clk) begin
      if (rst) pkt_cnt_reg <= '0;
      else if (xfer[go] && flit[1]) pkt_cnt_reg <= pkt_cnt_reg + 16'd1;
    end
    assign pkt_cnt_o[go*16 +: 16] = pkt_cnt_reg;
`endif
  end
endmodule

// File: tb/tb_wormhole_router.sv
// Directed self-checking bench for wormhole_router placed at node (1,2) of a 4x4 network.
module tb_wormhole_router;
  localparam int DATA_W = 16;
  localparam int INPORT = 7;
  localparam int OUTPORT = 7;

  logic clk = 1'b0;
  logic rst;
  logic [INPORT-1:0] valid_i;
  logic [INPORT*DATA_W-1:0] data_i;
  logic [OUTPORT-1:0] off_sigs_i;
  logic [OUTPORT-1:0] valid_o;
  logic [OUTPORT*DATA_W-1:0] data_o;
  logic [INPORT-1:0] off_sigs_o;
  logic [INPORT-1:0] err_o;
`ifdef ROUTER_PKT_CNT_EN
  logic [OUTPORT*16-1:0] pkt_cnt_o;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wormhole_router #(.curr_dim0(1), .curr_dim1(2)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .data_i(data_i), .off_sigs_i(off_sigs_i),
    .valid_o(valid_o), .data_o(data_o), .off_sigs_o(off_sigs_o), .err_o(err_o)
`ifdef ROUTER_PKT_CNT_EN
    , .pkt_cnt_o(pkt_cnt_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  function automatic logic [15:0] hf(input logic [1:0] d0, input logic [1:0] d1,
                                     input logic [9:0] pl, input logic tl);
    return {pl, d1, d0, tl, 1'b1};
  endfunction

  function automatic logic [15:0] bf(input logic [9:0] pl, input logic tl);
    return {pl, 4'b0000, tl, 1'b0};
  endfunction

  task automatic drive(input int p, input logic [15:0] f);
    valid_i[p] = 1'b1;
    data_i[p*DATA_W +: DATA_W] = f;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    valid_i = '0;
  endtask

  task automatic expect_out(input string tag, input int p, input logic v, input logic [15:0] f);
    logic [OUTPORT-1:0] mask;
    mask = v ? (OUTPORT'(1) << p) : '0;
    check({tag, "_valid"}, 32'(valid_o), 32'(mask));
    if (v) check({tag, "_data"}, 32'(data_o[p*DATA_W +: DATA_W]), 32'(f));
  endtask

  logic [15:0] f [12];
  logic [15:0] e [12];
  logic [11:0] ev;

  initial begin
    rst = 1'b1; valid_i = '0; data_i = '0; off_sigs_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(valid_o), 32'h0);
    check("rst_data", 32'(data_o[3*DATA_W +: DATA_W]), 32'h0);
    check("rst_err", 32'(err_o), 32'h0);
    check("rst_af", 32'(off_sigs_o), 32'h0);
    rst = 1'b0;

    // 1: local packet to (3,2) leaves on port 3, two cycles after each write
    f[0] = hf(2'd3, 2'd2, 10'h011, 1'b0); f[1] = bf(10'h012, 1'b0);
    f[2] = bf(10'h013, 1'b0);             f[3] = bf(10'h014, 1'b1);
    for (int k = 0; k < 6; k++) begin
      if (k < 4) drive(0, f[k]);
      step();
      expect_out($sformatf("t1_k%0d", k), 3, (k >= 1 && k <= 4), f[(k > 0) ? k-1 : 0]);
    end
    check("t1_data_hold", 32'(data_o[3*DATA_W +: DATA_W]), 32'(f[3]));
    check("t1_err", 32'(err_o), 32'h0);

    // 2: inputs 1 and 4 race for port 0; input 5 single-flit waits for the second tail
    f[0] = hf(2'd1, 2'd2, 10'h021, 1'b0); f[1] = bf(10'h022, 1'b0); f[2] = bf(10'h023, 1'b1);
    f[3] = hf(2'd1, 2'd2, 10'h041, 1'b0); f[4] = bf(10'h042, 1'b0); f[5] = bf(10'h043, 1'b1);
    f[6] = hf(2'd1, 2'd2, 10'h051, 1'b1);
    ev = 12'b0000_1111_1110;
    e[1] = f[0]; e[2] = f[1]; e[3] = f[2]; e[4] = f[3]; e[5] = f[4]; e[6] = f[5]; e[7] = f[6];
    e[0] = '0; e[8] = '0;
    for (int k = 0; k < 9; k++) begin
      if (k < 3) begin drive(1, f[k]); drive(4, f[k+3]); end
      if (k == 5) drive(5, f[6]);
      step();
      expect_out($sformatf("t2_k%0d", k), 0, ev[k], e[k]);
    end

    // 3: back-pressure on port 3 for 5 cycles mid-packet; input 2 must wait for the tail
    f[0] = hf(2'd3, 2'd2, 10'h031, 1'b0); f[1] = bf(10'h032, 1'b0); f[2] = bf(10'h033, 1'b0);
    f[3] = bf(10'h034, 1'b0);             f[4] = bf(10'h035, 1'b1); f[5] = hf(2'd3, 2'd2, 10'h036, 1'b1);
    ev = 12'b1111_0000_0110;
    e[0] = '0; e[1] = f[0]; e[2] = f[1]; e[8] = f[2]; e[9] = f[3]; e[10] = f[4]; e[11] = f[5];
    for (int k = 3; k < 8; k++) e[k] = '0;
    for (int k = 0; k < 13; k++) begin
      if (k < 5) drive(0, f[k]);
      if (k == 4) drive(2, f[5]);
      off_sigs_i[3] = (k >= 3 && k <= 7);
      step();
      expect_out($sformatf("t3_k%0d", k), 3, (k < 12) ? ev[k] : 1'b0, e[(k < 12) ? k : 0]);
    end

    // 4: nine writes into input 6 while port 3 is blocked
    off_sigs_i[3] = 1'b1;
    f[0] = hf(2'd3, 2'd2, 10'h060, 1'b0);
    for (int k = 1; k < 9; k++) f[k] = bf(10'(10'h060 + k), 1'b0);
    f[9] = bf(10'h06f, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      drive(6, f[k-1]);
      step();
      check($sformatf("t4_af_w%0d", k), 32'(off_sigs_o[6]), 32'(k >= 6));
      check($sformatf("t4_err_w%0d", k), 32'(err_o[6]), 32'(k == 9));
    end
    // release while writing the tail into the full FIFO: read and write in the same cycle
    off_sigs_i[3] = 1'b0;
    for (int j = 0; j < 10; j++) begin
      if (j == 0) drive(6, f[9]);
      step();
      if (j == 0) check("t4_af_full_rw", 32'(off_sigs_o[6]), 32'h1);
      expect_out($sformatf("t4_d%0d", j), 3, (j < 9), (j < 8) ? f[j] : f[9]);
    end
    check("t4_err_sticky", 32'(err_o[6]), 32'h1);

    // 5: orphan body flit on input 2, then single-flit packets to ports 1, 6, 4
    f[0] = bf(10'h070, 1'b0);
    f[1] = hf(2'd0, 2'd0, 10'h071, 1'b1);
    f[2] = hf(2'd1, 2'd3, 10'h072, 1'b1);
    f[3] = hf(2'd1, 2'd0, 10'h073, 1'b1);
    drive(2, f[0]); step(); expect_out("t5_k0", 0, 1'b0, 16'h0);
    drive(2, f[1]); step(); expect_out("t5_k1", 0, 1'b0, 16'h0);
    check("t5_err", 32'(err_o), 32'h44);
    drive(2, f[2]); step(); expect_out("t5_k2", 1, 1'b1, f[1]);
    drive(2, f[3]); step(); expect_out("t5_k3", 6, 1'b1, f[2]);
    step(); expect_out("t5_k4", 4, 1'b1, f[3]);
    step(); expect_out("t5_k5", 0, 1'b0, 16'h0);

    // 6: reset mid-packet, then a fresh packet from another input on the same output
    drive(0, hf(2'd3, 2'd2, 10'h080, 1'b0)); step();
    drive(0, bf(10'h081, 1'b0)); step();
    expect_out("t6_pre", 3, 1'b1, hf(2'd3, 2'd2, 10'h080, 1'b0));
    rst = 1'b1;
    step();
    check("t6_rst_valid", 32'(valid_o), 32'h0);
    check("t6_rst_data3", 32'(data_o[3*DATA_W +: DATA_W]), 32'h0);
    check("t6_rst_data4", 32'(data_o[4*DATA_W +: DATA_W]), 32'h0);
    check("t6_rst_err", 32'(err_o), 32'h0);
    step();
    rst = 1'b0;
    f[0] = hf(2'd3, 2'd2, 10'h090, 1'b0); f[1] = bf(10'h091, 1'b1);
    drive(1, f[0]); step(); expect_out("t6_k0", 3, 1'b0, 16'h0);
    drive(1, f[1]); step(); expect_out("t6_k1", 3, 1'b1, f[0]);
    step(); expect_out("t6_k2", 3, 1'b1, f[1]);
    step(); expect_out("t6_k3", 3, 1'b0, 16'h0);
    check("t6_err", 32'(err_o), 32'h0);
`ifdef ROUTER_PKT_CNT_EN
    check("t6_pkt_cnt3", 32'(pkt_cnt_o[3*16 +: 16]), 32'h1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wormhole_router.md
Name: wormhole_router

Overview:
- Next-generation flattened-butterfly router node that moves multi-flit packets under wormhole switching.
- Input FIFOs buffer flits. The head flit computes a dimension-order route, and a per-output allocator locks the output to one input from head flit to tail flit.
- Outputs are registered. Downstream back-pressure arrives on off_sigs_i.
- One instance sits at each node (curr_dim0, curr_dim1) of the NODE_PER_ROW x NODE_PER_COL network.

Parameters:
- DATA_W, 16, flit width including the 2 control bits.
- FIFO_DEPTH, 8, input FIFO depth per port (power of 2, >=4).
- NODE_PER_ROW, 4, nodes in dim0.
- NODE_PER_COL, 4, nodes in dim1.
- INPORT, 7, input ports including local; must equal NODE_PER_ROW+NODE_PER_COL-1.
- OUTPORT, 7, output ports including local; same constraint as INPORT.
- AF_SLACK, 2, almost-full asserts when occupancy >= FIFO_DEPTH-AF_SLACK.
- curr_dim0, 0, this node's dim0 coordinate.
- curr_dim1, 0, this node's dim1 coordinate.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- valid_i  in  INPORT  per-port flit write strobe.
- data_i  in  INPORT*DATA_W  flits, port v at [DATA_W*v +: DATA_W].
- off_sigs_i  in  OUTPORT  downstream almost-full; 1 = do not send on that output.
- valid_o  out  OUTPORT  registered flit valid.
- data_o  out  OUTPORT*DATA_W  registered flits.
- off_sigs_o  out  INPORT  input FIFO almost-full, combinational from occupancy.
- err_o  out  INPORT  sticky per-input error flag.

Interface fixed: single clock clk; reset rst is synchronous, active-high.

Behaviour:
- Flit format:
  - bit 0 = head, bit 1 = tail. A single-flit packet has both set.
  - On head flits, dest dim0 is at [2 +: DIM0_W] and dest dim1 is at [2+DIM0_W +: DIM1_W], where DIMx_W = $clog2(NODE_PER_x).
- Port map:
  - Port 0 is local.
  - Dim0 peer d maps to port 1+(d<curr_dim0 ? d : d-1).
  - Dim1 peer d maps to port NODE_PER_ROW+(d<curr_dim1 ? d : d-1).
- Route rule: if dest dim0 != curr_dim0, use the dim0 port. Otherwise, if dest dim1 != curr_dim1, use the dim1 port. Otherwise use port 0.
- Input state machine, per input:
  - IDLE: a head flit at the FIFO front computes its route and requests that output.
    - On grant, the flit is popped and forwarded, and the route is latched.
    - The input moves to ACTIVE unless the flit is also a tail.
  - IDLE, non-head flit at the front: the flit is popped and discarded, and err_o[v] sets.
  - ACTIVE: every flit, regardless of its head bit, goes to the latched output.
    - Popping a tail returns the input to IDLE.
- Output allocator, per output:
  - FREE: round-robin among requesting IDLE inputs. The pointer moves to one past the winner. Reset priority is input 0.
  - LOCKED(owner): only the owner is served. The output returns to FREE in the cycle its tail is forwarded. A new head can be granted the following cycle.
  - Single-flit packets never lock the output.
- Transfer rule:
  - A flit moves when its FIFO is non-empty, the output is granted or locked to that input, and off_sigs_i[out]==0.
  - With off_sigs_i high, the lock is held, nothing pops, and valid_o[out]=0.
- Output register: valid_o and data_o load on transfer. In any cycle without a transfer, valid_o=0 and data_o holds its last value.
- Latency: flit written at cycle t is at the FIFO front at t+1 and appears on valid_o/data_o at t+2 (zero contention). Throughput is 1 flit/cycle/output.
- FIFO: a simultaneous read and write when full or empty behaves correctly; occupancy is unchanged. A write while full (no read that cycle) drops the flit and sets err_o[v].
- Reset: mid-packet reset flushes all FIFOs, frees all locks, returns all inputs to IDLE and round-robin pointers to 0. valid_o=0, data_o=0, err_o=0 after reset.
- err_o clears only on rst.

Optional Feature:
- Macro: ROUTER_PKT_CNT_EN.
- Defined: adds port pkt_cnt_o, out, OUTPORT*16 bits. Each 16-bit slice counts tail flits forwarded on that output, wraps at 0xFFFF->0, and resets to 0.
- Undefined: the port and counters are absent. All other behaviour is identical.

Test Plan:
- Node (1,2), default params, local head flit to dest (3,2) plus 2 body flits and a tail -> 4 flits on port 3 at cycles t+2..t+5 in order; err_o=0.
- Inputs 1 and 4 both send 3-flit packets to local port 0 in the same cycle -> input 1 packet fully delivered first with no interleaving, then input 4 packet; port 0 free one cycle after the second tail.
- off_sigs_i[3]=1 for 5 cycles mid-packet -> valid_o[3]=0 for those cycles, lock held, delivery resumes with no flit loss or duplication.
- 9 writes to one input with the output blocked (FIFO_DEPTH=8) -> off_sigs_o high from the 6th write, 9th flit dropped, err_o sticky 1.
- Body flit with no preceding head -> discarded, err_o set, next valid packet routed correctly.
- Assert rst mid-packet, then send a fresh packet -> all outputs 0 during reset; new packet delivered normally. With ROUTER_PKT_CNT_EN, pkt_cnt_o slice = 1.
